scpad_req_arbiter: RTL
======================

# scpad_req_arbiter

Starvation-bounded arbiter that shares the scratchpad SRAM controller's read and write request ports between the frontend (VC/SA) and the backend (DRAM/queue-pair) request generators. Frontend has default priority, but a backend request is forced through after a bounded wait. The arbiter registers the granted request into a one-entry output stage and stamps the source into `int_id[1]` so the response demux routes correctly. It sits between `frontend`/`backend` and `sram_cntrl`, one lane per channel (read, write).

## Interface
Parameters:
- `STARVE_LIMIT`, 8: number of cycles a valid backend request may be refused before forced grant; legal range 1..255.
- `CNT_W`, `$clog2(STARVE_LIMIT+1)`: starvation counter width (derived).

Ports:
- `clk` in 1: clock.
- `n_rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `fe_rd_req` in `sram_r_req_t`: frontend read request; `.valid` qualifies.
- `fe_rd_ready` out 1: frontend read request accepted this cycle.
- `be_rd_req` in `sram_r_req_t`: backend read request.
- `be_rd_ready` out 1: backend read request accepted this cycle.
- `fe_wr_req` / `be_wr_req` in `sram_w_req_t`: write requests.
- `fe_wr_ready` / `be_wr_ready` out 1: write acceptances.
- `sram_rd_req` out `sram_r_req_t`: registered read request to `sram_cntrl`.
- `sram_rd_ready` in 1: `sram_cntrl` consumes `sram_rd_req` this cycle.
- `sram_wr_req` out `sram_w_req_t`: registered write request.
- `sram_wr_ready` in 1: `sram_cntrl` consumes `sram_wr_req`.
- `rd_boost` / `wr_boost` out 1: lane is in BE_BOOST state (debug/perf visibility).

## Operation
- Read and write lanes are identical and fully independent; there is no cross-lane interaction.
- Handshake: a request transfers when `.valid && ready`. The requester holds its payload stable until accepted. `ready` is never asserted without `.valid`.
- Slot free: `slot_free = !out.valid || sram_*_ready`.
- Lane FSM, two states:
  - FE_PRIO (reset state):
    - If `fe.valid`, grant frontend.
    - Else if `be.valid`, grant backend.
    - A cycle with `be.valid` and no backend grant increments the counter.
    - When the counter reaches `STARVE_LIMIT`, go to BE_BOOST.
  - BE_BOOST:
    - Backend has priority over frontend.
    - On backend grant, clear the counter and return to FE_PRIO.
    - If `be.valid` drops before grant (illegal per handshake), also clear and return.
- A backend grant in FE_PRIO clears the counter. The counter saturates at `STARVE_LIMIT` and never wraps.
- No grant occurs when `!slot_free`. Counter increments still apply while the slot is blocked.
- On grant, the output register loads the request with `int_id[1]` overwritten: 0 = frontend, 1 = backend. All other payload fields pass unmodified.
- Simultaneous grant and output consume (`sram_*_ready` with a new grant): the register reloads; no bubble.

## Timing
- Accept-to-output latency: 1 cycle. The request accepted in cycle N appears on `sram_*_req` in N+1.
- Full throughput: one request per lane per cycle when `sram_*_ready` stays high.
- Backend worst-case wait under continuous frontend traffic with a free slot: `STARVE_LIMIT` refused cycles, then grant on cycle `STARVE_LIMIT+1`.
- `ready` outputs are combinational from `valid`, FSM state and `slot_free`.
- Reset values (async, `n_rst` low):
  - `sram_*_req.valid=0`, payload 0.
  - FSM=FE_PRIO, counters 0.
  - `*_ready=0`, `*_boost=0`.
- Reset mid-transfer drops the held request; requesters must reissue.

## Configuration
- `SCPAD_ARB_PERF_EN` defined: adds per-lane 32-bit saturating counters, read-only outputs:
  - `rd_fe_grants`, `rd_be_grants`, `rd_boost_events`
  - `wr_fe_grants`, `wr_be_grants`, `wr_boost_events`
  - Counters reset to 0 and increment on the respective grant or FE_PRIO→BE_BOOST transition.
- Undefined: those ports and counters do not exist; arbitration behaviour is identical.

## Structure
- `scpad_types_pkg` holds `sram_r_req_t` and `sram_w_req_t` (existing), plus:
  - `SCPAD_ARB_STARVE_LIMIT_DEFAULT` constant.
  - `arb_state_e` enum {FE_PRIO, BE_BOOST}.
  - `INT_ID_SRC_FE=1'b0` and `INT_ID_SRC_BE=1'b1` constants, shared with the response demux.
- Sub-module `scpad_arb_lane`, parameterized by payload type, instantiated twice (read, write). The top contains only the instances and perf-counter wiring.

## Test plan
- Frontend only: `fe_rd_req.valid` for 4 cycles, `sram_rd_ready=1` → 4 outputs back-to-back, each one cycle later, all `int_id[1]=0`, `be_rd_ready=0` throughout.
- Starvation: `STARVE_LIMIT=8`, frontend and backend reads valid continuously, sink ready → 8 frontend grants, then `rd_boost=1` and `be_rd_ready=1` on cycle 9, output `int_id[1]=1` in cycle 10, then frontend resumes.
- Backpressure: `sram_wr_ready=0` for 5 cycles with an output held → `fe/be_wr_ready=0`, output payload stable. Release → held request consumed and a new grant loads in the same cycle.
- Lane independence: read lane in BE_BOOST while the write lane carries frontend-only traffic → write grants unaffected, `wr_boost=0`.
- Async reset: assert `n_rst` low mid-cycle with `sram_rd_req.valid=1` and counter=5 → `valid=0`, counter 0, FE_PRIO immediately, without waiting for a clock edge.
- `SCPAD_ARB_PERF_EN`: the starvation scenario run 3 times → `rd_boost_events=3`, `rd_be_grants=3`, `rd_fe_grants=24`.

Source files
------------

// File: rtl/scpad_types_pkg.sv
// Shared scratchpad request types plus the arbiter state/source-id constants
// used by scpad_req_arbiter and the response demux.
package scpad_types_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  int_id;
    logic [15:0] addr;
  } sram_r_req_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  int_id;
    logic [15:0] addr;
    logic [31:0] data;
  } sram_w_req_t;

  localparam int SCPAD_ARB_STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic {
    FE_PRIO  = 1'b0,
    BE_BOOST = 1'b1
  } arb_state_e;

  // int_id[1] source tag, decoded by the response demux
  localparam logic INT_ID_SRC_FE = 1'b0;
  localparam logic INT_ID_SRC_BE = 1'b1;

endpackage

// File: rtl/scpad_arb_lane.sv
// One arbitration lane: frontend-priority grant with bounded backend starvation,
// feeding a one-entry registered output stage. Payload type is a parameter.
module scpad_arb_lane
  import scpad_types_pkg::*;
#(
  parameter type req_t        = sram_r_req_t,
  parameter int  STARVE_LIMIT = SCPAD_ARB_STARVE_LIMIT_DEFAULT,
  parameter int  CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  req_t fe_req,
  output logic fe_ready,
  input  req_t be_req,
  output logic be_ready,
  output req_t out_req,
  input  logic out_ready,
  output logic boost,
  output logic fe_grant,
  output logic be_grant,
  output logic boost_evt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             slot_free;

  assign slot_free = !out_req.valid || out_ready;
  assign cnt_inc   = (cnt == LIMIT) ? cnt : cnt + CNT_W'(1);

  // Grants are gated by n_rst so ready stays low while reset is held.
  always_comb begin
    fe_grant = 1'b0;
    be_grant = 1'b0;
    if (n_rst && slot_free) begin
      if (state == BE_BOOST) begin
        be_grant = be_req.valid;
        fe_grant = fe_req.valid && !be_req.valid;
      end else begin
        fe_grant = fe_req.valid;
        be_grant = be_req.valid && !fe_req.valid;
      end
    end
  end

  assign fe_ready  = fe_grant;
  assign be_ready  = be_grant;
  assign boost     = (state == BE_BOOST);
  assign boost_evt = (state == FE_PRIO) && be_req.valid && !be_grant && (cnt_inc == LIMIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= FE_PRIO;
      cnt     <= '0;
      out_req <= '0;
    end else begin
      case (state)
        FE_PRIO: begin
          // Refused cycles count even while the output slot is blocked.
          if (be_grant) begin
            cnt <= '0;
          end else if (be_req.valid) begin
            cnt <= cnt_inc;
            if (cnt_inc == LIMIT) state <= BE_BOOST;
          end
        end
        BE_BOOST: begin
          if (be_grant || !be_req.valid) begin
            cnt   <= '0;
            state <= FE_PRIO;
          end
        end
      endcase

      if (fe_grant) begin
        out_req           <= fe_req;
        out_req.int_id[1] <= INT_ID_SRC_FE;
      end else if (be_grant) begin
        out_req           <= be_req;
        out_req.int_id[1] <= INT_ID_SRC_BE;
      end else if (out_ready) begin
        out_req.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scpad_req_arbiter.sv
// Read/write request arbiter between frontend/backend and sram_cntrl.
// Optional perf counters: define SCPAD_ARB_PERF_EN.
module scpad_req_arbiter
  import scpad_types_pkg::*;
#(
  parameter int STARVE_LIMIT = SCPAD_ARB_STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        n_rst,
  input  sram_r_req_t fe_rd_req,
  output logic        fe_rd_ready,
  input  sram_r_req_t be_rd_req,
  output logic        be_rd_ready,
  input  sram_w_req_t fe_wr_req,
  output logic        fe_wr_ready,
  input  sram_w_req_t be_wr_req,
  output logic        be_wr_ready,
  output sram_r_req_t sram_rd_req,
  input  logic        sram_rd_ready,
  output sram_w_req_t sram_wr_req,
  input  logic        sram_wr_ready,
  output logic        rd_boost,
  output logic        wr_boost
`ifdef SCPAD_ARB_PERF_EN
  ,
  output logic [31:0] rd_fe_grants,
  output logic [31:0] rd_be_grants,
  output logic [31:0] rd_boost_events,
  output logic [31:0] wr_fe_grants,
  output logic [31:0] wr_be_grants,
  output logic [31:0] wr_boost_events
`endif
);

  logic rd_fe_grant, rd_be_grant, rd_boost_evt;
  logic wr_fe_grant, wr_be_grant, wr_boost_evt;

  scpad_arb_lane #(.req_t(sram_r_req_t), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_rd_lane (
    .clk       (clk),
    .n_rst     (n_rst),
    .fe_req    (fe_rd_req),
    .fe_ready  (fe_rd_ready),
    .be_req    (be_rd_req),
    .be_ready  (be_rd_ready),
    .out_req   (sram_rd_req),
    .out_ready (sram_rd_ready),
    .boost     (rd_boost),
    .fe_grant  (rd_fe_grant),
    .be_grant  (rd_be_grant),
    .boost_evt (rd_boost_evt)
  );

  scpad_arb_lane #(.req_t(sram_w_req_t), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_wr_lane (
    .clk       (clk),
    .n_rst     (n_rst),
    .fe_req    (fe_wr_req),
    .fe_ready  (fe_wr_ready),
    .be_req    (be_wr_req),
    .be_ready  (be_wr_ready),
    .out_req   (sram_wr_req),
    .out_ready (sram_wr_ready),
    .boost     (wr_boost),
    .fe_grant  (wr_fe_grant),
    .be_grant  (wr_be_grant),
    .boost_evt (wr_boost_evt)
  );

`ifdef SCPAD_ARB_PERF_EN
  // [lane][event]: lane 0 = read, 1 = write; event 0 = fe, 1 = be, 2 = boost
  logic [1:0][2:0]       evt;
  logic [1:0][2:0][31:0] perf;

  assign evt[0] = {rd_boost_evt, rd_be_grant, rd_fe_grant};
  assign evt[1] = {wr_boost_evt, wr_be_grant, wr_fe_grant};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf <= '0;
    end else begin
      for (int l = 0; l < 2; l++)
        for (int k = 0; k < 3; k++)
          if (evt[l][k] && (perf[l][k] != '1)) perf[l][k] <= perf[l][k] + 32'd1;
    end
  end

  assign rd_fe_grants    = perf[0][0];
  assign rd_be_grants    = perf[0][1];
  assign rd_boost_events = perf[0][2];
  assign wr_fe_grants    = perf[1][0];
  assign wr_be_grants    = perf[1][1];
  assign wr_boost_events = perf[1][2];
`else
  logic unused_perf;
  assign unused_perf = ^{rd_fe_grant, rd_be_grant, rd_boost_evt,
                         wr_fe_grant, wr_be_grant, wr_boost_evt};
`endif

endmodule
